// File: rtl/control.sv
// Greenhouse vent controller: registers the inputs, applies a hysteresis band around
// SETPOINT and enforces a minimum dwell on the registered vent enable.
module control #(
  parameter int SETPOINT  = 20,
  parameter int HYST      = 3,
  parameter int MIN_DWELL = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic signed [7:0] greenhouse_temp,
  input  logic              temp_g_greenhouse_temp,
  output logic              out
);

  localparam int DATA_W = 8;
  localparam int EXT_W  = 10;
  localparam int CNT_W  = (MIN_DWELL > 1) ? $clog2(MIN_DWELL) : 1;
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(MIN_DWELL - 1);

  // Thresholds are formed at 10 bits so SETPOINT+HYST cannot wrap at the 8-bit range edge.
  localparam logic signed [EXT_W-1:0] SP_X = EXT_W'(SETPOINT);
  localparam logic signed [EXT_W-1:0] HY_X = EXT_W'(HYST);
  localparam logic signed [EXT_W-1:0] LO_X = SP_X - HY_X;
  localparam logic signed [EXT_W-1:0] HI_X = SP_X + HY_X;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    VENT_WARM = 2'd1,
    VENT_COOL = 2'd2
  } state_t;

  function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  logic signed [DATA_W-1:0] gt_q;
  logic                     tg_q;
  logic signed [EXT_W-1:0]  gt_x;
  logic                     cold;
  logic                     hot;
  logic                     dwell_done;
  logic [CNT_W-1:0]         dwell;
  state_t                   state;
  state_t                   state_nxt;
  logic                     out_nxt;

  // Stage 0: input capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gt_q <= '0;
      tg_q <= 1'b0;
    end else begin
      gt_q <= greenhouse_temp;
      tg_q <= temp_g_greenhouse_temp;
    end
  end

  // Stage 1: band compare, FSM, dwell counter and registered vent enable
  assign gt_x       = {{(EXT_W-DATA_W){gt_q[DATA_W-1]}}, gt_q};
  assign cold       = (gt_x <= LO_X);
  assign hot        = (gt_x >= HI_X);
  assign dwell_done = (dwell == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      dwell <= '0;
      out   <= 1'b0;
    end else begin
      state <= state_nxt;
      dwell <= (state_nxt != state) ? DWELL_LOAD : sat_dec(dwell);
      out   <= out_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (dwell_done) begin
      case (state)
        IDLE: begin
          if (cold && tg_q)       state_nxt = VENT_WARM;
          else if (hot && !tg_q)  state_nxt = VENT_COOL;
        end
        VENT_WARM: if (gt_x >= SP_X || !tg_q) state_nxt = IDLE;
        VENT_COOL: if (gt_x <= SP_X || tg_q)  state_nxt = IDLE;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    out_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_control.sv
// Directed bench for the vent controller: hand-computed out sequences for each scenario,
// plus a second instance with a high setpoint to exercise the range extremes.
module tb_control;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic signed [7:0] gt  = '0;
  logic              tg  = 1'b0;
  logic              out;
  logic signed [7:0] gt2 = '0;
  logic              tg2 = 1'b0;
  logic              out2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  control #(.SETPOINT(20), .HYST(3), .MIN_DWELL(4)) dut (
    .clk(clk), .rst(rst), .greenhouse_temp(gt),
    .temp_g_greenhouse_temp(tg), .out(out)
  );

  control #(.SETPOINT(120), .HYST(10), .MIN_DWELL(4)) dut_hi (
    .clk(clk), .rst(rst), .greenhouse_temp(gt2),
    .temp_g_greenhouse_temp(tg2), .out(out2)
  );

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Neutral stimulus that closes the vent from any state and lets the dwell expire.
  task automatic go_idle();
    gt = 8'sd20; tg = 1'b0;
    tick(10);
  endtask

  task automatic test_reset();
    gt = 8'sd0; tg = 1'b0; rst = 1'b0;
    tick(3);
    checks++;
    if (out !== 1'b0) begin errors++; $display("FAIL reset_hold: out=%0b expected 0", out); end
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checks++;
      if (out !== 1'b0) begin errors++; $display("FAIL reset_release[%0d]: out=%0b expected 0", i, out); end
    end
  endtask

  task automatic test_warm();
    gt = 8'sd10; tg = 1'b1;
    tick(1);
    checks++;
    if (out !== 1'b0) begin errors++; $display("FAIL warm_lat1: out=%0b expected 0", out); end
    tick(1);
    checks++;
    if (out !== 1'b1) begin errors++; $display("FAIL warm_open: out=%0b expected 1", out); end
    gt = 8'sd19;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      checks++;
      if (out !== 1'b1) begin errors++; $display("FAIL warm_hold19[%0d]: out=%0b expected 1", i, out); end
    end
    gt = 8'sd20;
    tick(1);
    checks++;
    if (out !== 1'b1) begin errors++; $display("FAIL warm_close_lat1: out=%0b expected 1", out); end
    tick(1);
    checks++;
    if (out !== 1'b0) begin errors++; $display("FAIL warm_close: out=%0b expected 0", out); end
    go_idle();
  endtask

  task automatic test_band();
    logic signed [7:0] band_t [4];
    logic              band_g [4];
    band_t = '{8'sd18, 8'sd18, 8'sd22, 8'sd22};
    band_g = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int v = 0; v < 4; v++) begin
      gt = band_t[v]; tg = band_g[v];
      for (int i = 0; i < 4; i++) begin
        tick(1);
        checks++;
        if (out !== 1'b0)
          begin errors++; $display("FAIL band_in t=%0d g=%0b [%0d]: out=%0b expected 0", band_t[v], band_g[v], i, out); end
      end
    end
    gt = 8'sd23; tg = 1'b0;
    tick(1);
    checks++;
    if (out !== 1'b0) begin errors++; $display("FAIL band_hot_lat1: out=%0b expected 0", out); end
    tick(1);
    checks++;
    if (out !== 1'b1) begin errors++; $display("FAIL band_hot_edge: out=%0b expected 1", out); end
    go_idle();
    checks++;
    if (out !== 1'b0) begin errors++; $display("FAIL band_cool_close: out=%0b expected 0", out); end
    gt = 8'sd17; tg = 1'b1;
    tick(1);
    checks++;
    if (out !== 1'b0) begin errors++; $display("FAIL band_cold_lat1: out=%0b expected 0", out); end
    tick(1);
    checks++;
    if (out !== 1'b1) begin errors++; $display("FAIL band_cold_edge: out=%0b expected 1", out); end
    go_idle();
  endtask

  task automatic test_back_to_back();
    logic exp_seq [8];
    exp_seq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    gt = 8'sd10; tg = 1'b1;
    tick(2);
    checks++;
    if (out !== 1'b1) begin errors++; $display("FAIL rev_open: out=%0b expected 1", out); end
    gt = 8'sd25; tg = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      checks++;
      if (out !== exp_seq[i]) begin errors++; $display("FAIL rev_seq[%0d]: out=%0b expected %0b", i, out, exp_seq[i]); end
    end
    go_idle();
  endtask

  task automatic test_extremes();
    gt = -8'sd128; tg = 1'b1;
    tick(1);
    checks++;
    if (out !== 1'b0) begin errors++; $display("FAIL ext_min_lat1: out=%0b expected 0", out); end
    tick(1);
    checks++;
    if (out !== 1'b1) begin errors++; $display("FAIL ext_min_open: out=%0b expected 1", out); end
    go_idle();
    gt = 8'sd127; tg = 1'b0;
    tick(2);
    checks++;
    if (out !== 1'b1) begin errors++; $display("FAIL ext_max_open: out=%0b expected 1", out); end
    go_idle();
    // SETPOINT=120, HYST=10: hot threshold 130 is unreachable, so 127 must not open.
    gt2 = 8'sd127; tg2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      checks++;
      if (out2 !== 1'b0) begin errors++; $display("FAIL ext_hi_nowrap[%0d]: out=%0b expected 0", i, out2); end
    end
    gt2 = -8'sd128; tg2 = 1'b1;
    tick(1);
    checks++;
    if (out2 !== 1'b0) begin errors++; $display("FAIL ext_hi_min_lat1: out=%0b expected 0", out2); end
    tick(1);
    checks++;
    if (out2 !== 1'b1) begin errors++; $display("FAIL ext_hi_min_open: out=%0b expected 1", out2); end
  endtask

  task automatic test_reset_mid();
    gt = 8'sd10; tg = 1'b1;
    tick(2);
    checks++;
    if (out !== 1'b1) begin errors++; $display("FAIL mid_open: out=%0b expected 1", out); end
    #3 rst = 1'b0;
    #1;
    checks++;
    if (out !== 1'b0) begin errors++; $display("FAIL mid_async: out=%0b expected 0", out); end
    tick(1);
    rst = 1'b1;
    tick(1);
    checks++;
    if (out !== 1'b0) begin errors++; $display("FAIL mid_release_lat1: out=%0b expected 0", out); end
    tick(1);
    checks++;
    if (out !== 1'b1) begin errors++; $display("FAIL mid_release_open: out=%0b expected 1", out); end
  endtask

  initial begin
    test_reset();
    test_warm();
    test_band();
    test_back_to_back();
    test_extremes();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
